// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Timing-and-control sequencer for the basic-computer fetch datapath.
// Walks each instruction through fetch (T0, T1), decode (T2) and an optional
// indirect-address cycle (T3). It then starts the execute unit and waits for
// its done handshake before moving on to the next instruction or going idle.
// Every strobe is a function of the state alone. The strobes are registered
// from the next state, so each one is glitch-free and lines up with the
// state it belongs to.

module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] ir_data,
    input  logic        exec_done,
    output logic [2:0]  s,
    output logic        ar_ld,
    output logic        pc_inr,
    output logic        ir_ld,
    output logic        mem_read,
    output logic        exec_start,
    output logic [7:0]  d,
    output logic        i_bit,
    output logic [2:0]  sc,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        T0       = 3'd1,
        T1       = 3'd2,
        T2       = 3'd3,
        T3       = 3'd4,
        EX_START = 3'd5,
        EX_WAIT  = 3'd6
    } state_t;

    // Bus source select codes
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_PC   = 3'b010;
    localparam logic [2:0] SEL_IR   = 3'b101;
    localparam logic [2:0] SEL_MEM  = 3'b111;

    // Opcode 111 marks register-reference / I/O instructions, which have no
    // memory operand and therefore never go through the indirect cycle.
    localparam logic [2:0] OP_REG_IO = 3'b111;

    // Everything the sequencer drives toward the datapath, bundled so that
    // one decode function covers all of it.
    typedef struct packed {
        logic [2:0] sel;
        logic       arLd;
        logic       pcInr;
        logic       irLd;
        logic       memRead;
        logic       execStart;
        logic [2:0] count;
        logic       busyFlag;
    } ctrl_t;

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [7:0] d_q, d_d;
    logic       i_bit_q, i_bit_d;
    logic       indirect;
    logic       unused_ir_addr;

    // Address field of IR is consumed by the datapath directly, not here
    assign unused_ir_addr = ^ir_data[11:0];

    // Control word for a given state: bus select, strobes, timing count, busy
    function automatic ctrl_t decodeCtrl(input state_t st);
        ctrl_t c;
        c           = '0;
        c.sel       = SEL_NONE;
        c.count     = 3'd7;
        c.busyFlag  = 1'b1;
        case (st)
            IDLE: begin
                c.busyFlag = 1'b0;
                c.count    = 3'd7;
            end
            T0: begin
                c.sel   = SEL_PC;
                c.arLd  = 1'b1;
                c.count = 3'd0;
            end
            T1: begin
                c.sel     = SEL_MEM;
                c.memRead = 1'b1;
                c.irLd    = 1'b1;
                c.pcInr   = 1'b1;
                c.count   = 3'd1;
            end
            T2: begin
                c.sel   = SEL_IR;
                c.arLd  = 1'b1;
                c.count = 3'd2;
            end
            T3: begin
                c.sel     = SEL_MEM;
                c.memRead = 1'b1;
                c.arLd    = 1'b1;
                c.count   = 3'd3;
            end
            EX_START: begin
                c.execStart = 1'b1;
                c.count     = 3'd4;
            end
            EX_WAIT: begin
                c.count = 3'd4;
            end
            default: begin
                c.busyFlag = 1'b0;
                c.count    = 3'd7;
            end
        endcase
        return c;
    endfunction

    // An instruction goes indirect only when I=1 and it references memory
    assign indirect = ir_data[15] && (ir_data[14:12] != OP_REG_IO);

    // Next-state logic plus next values of the decode registers
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        i_bit_d = i_bit_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = T0;
                end
            end
            T0: begin
                state_d = T1;
            end
            T1: begin
                state_d = T2;
            end
            T2: begin
                d_d     = 8'b1 << ir_data[14:12];
                i_bit_d = ir_data[15];
                state_d = indirect ? T3 : EX_START;
            end
            T3: begin
                state_d = EX_START;
            end
            EX_START, EX_WAIT: begin
                if (exec_done) begin
                    state_d = run ? T0 : IDLE;
                end else begin
                    state_d = EX_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ctrl_d = decodeCtrl(state_d);
    end

    // State, registered control word and decode registers; reset abandons any instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ctrl_q  <= decodeCtrl(IDLE);
            d_q     <= 8'h00;
            i_bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            d_q     <= d_d;
            i_bit_q <= i_bit_d;
        end
    end

    assign s          = ctrl_q.sel;
    assign ar_ld      = ctrl_q.arLd;
    assign pc_inr     = ctrl_q.pcInr;
    assign ir_ld      = ctrl_q.irLd;
    assign mem_read   = ctrl_q.memRead;
    assign exec_start = ctrl_q.execStart;
    assign sc         = ctrl_q.count;
    assign busy       = ctrl_q.busyFlag;
    assign d          = d_q;
    assign i_bit      = i_bit_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Drives fetch_sequencer against a small model of the basic-computer
// datapath (PC, AR, IR, memory, bus mux). Expected behaviour comes from a
// per-instruction phase list: T0, T1, T2, an optional T3, EX_START, then
// EX_WAIT until done. The bench also predicts the opcode decode, the final
// AR and the PC increment for each instruction.

module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] ir_data;
    logic        exec_done;
    logic [2:0]  s;
    logic        ar_ld;
    logic        pc_inr;
    logic        ir_ld;
    logic        mem_read;
    logic        exec_start;
    logic [7:0]  d;
    logic        i_bit;
    logic [2:0]  sc;
    logic        busy;

    int checkCount;
    int errCount;

    // Expected {busy, sc, s, ar_ld, pc_inr, ir_ld, mem_read, exec_start} per phase
    localparam logic [11:0] PH_IDLE = {1'b0, 3'd7, 3'b000, 5'b00000};
    localparam logic [11:0] PH_T0   = {1'b1, 3'd0, 3'b010, 5'b10000};
    localparam logic [11:0] PH_T1   = {1'b1, 3'd1, 3'b111, 5'b01110};
    localparam logic [11:0] PH_T2   = {1'b1, 3'd2, 3'b101, 5'b10000};
    localparam logic [11:0] PH_T3   = {1'b1, 3'd3, 3'b111, 5'b10010};
    localparam logic [11:0] PH_EXS  = {1'b1, 3'd4, 3'b000, 5'b00001};
    localparam logic [11:0] PH_WAIT = {1'b1, 3'd4, 3'b000, 5'b00000};

    logic [15:0] mem [4096];
    logic [11:0] pcReg;
    logic [11:0] arReg;
    logic [15:0] irReg;
    logic [15:0] bus;
    logic [11:0] obs;
    logic [11:0] modelPc;

    fetch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir_data    (ir_data),
        .exec_done  (exec_done),
        .s          (s),
        .ar_ld      (ar_ld),
        .pc_inr     (pc_inr),
        .ir_ld      (ir_ld),
        .mem_read   (mem_read),
        .exec_start (exec_start),
        .d          (d),
        .i_bit      (i_bit),
        .sc         (sc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs     = {busy, sc, s, ar_ld, pc_inr, ir_ld, mem_read, exec_start};
    assign ir_data = irReg;

    // Shared system bus: the source is picked by the sequencer's select code
    always_comb begin
        bus = 16'h0000;
        case (s)
            3'b010:  bus = {4'h0, pcReg};
            3'b101:  bus = irReg;
            3'b111:  bus = mem[arReg];
            default: bus = 16'h0000;
        endcase
    end

    // Datapath registers respond to the sequencer's strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcReg <= 12'h000;
            arReg <= 12'h000;
            irReg <= 16'h0000;
        end else begin
            if (ar_ld)  arReg <= bus[11:0];
            if (pc_inr) pcReg <= pcReg + 12'd1;
            if (ir_ld)  irReg <= bus;
        end
    end

    // Counts one comparison and reports it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one instruction; entered and left at a negedge with the DUT in T0
    // (or in IDLE on exit when runAfter is 0)
    task automatic applyStimulus(input logic [15:0] word, input logic [15:0] indWord,
                                 input int waitCycles, input bit runAfter);
        bit          indirect;
        logic [11:0] expAr;
        logic [7:0]  expD;
        indirect = word[15] && (word[14:12] != 3'b111);
        expAr    = indirect ? indWord[11:0] : word[11:0];
        expD     = 8'h01 << word[14:12];
        mem[modelPc] = word;
        if (indirect) mem[word[11:0]] = indWord;

        checkOutput("T0 ctrl", {20'h0, obs}, {20'h0, PH_T0});
        checkOutput("T0 pc", {20'h0, pcReg}, {20'h0, modelPc});
        exec_done = 1'($urandom);
        stepCycle();
        checkOutput("T1 ctrl", {20'h0, obs}, {20'h0, PH_T1});
        exec_done = 1'($urandom);
        run = runAfter ? 1'($urandom) : 1'b0;
        stepCycle();
        checkOutput("T2 ctrl", {20'h0, obs}, {20'h0, PH_T2});
        exec_done = 1'($urandom);
        if (indirect) begin
            stepCycle();
            checkOutput("T3 ctrl", {20'h0, obs}, {20'h0, PH_T3});
            checkOutput("T3 d", {24'h0, d}, {24'h0, expD});
            exec_done = 1'($urandom);
        end
        stepCycle();
        checkOutput("EXS ctrl", {20'h0, obs}, {20'h0, PH_EXS});
        checkOutput("EXS d", {24'h0, d}, {24'h0, expD});
        checkOutput("EXS i_bit", {31'h0, i_bit}, {31'h0, word[15]});
        checkOutput("EXS ar", {20'h0, arReg}, {20'h0, expAr});
        checkOutput("EXS pc", {20'h0, pcReg}, {20'h0, modelPc + 12'd1});
        modelPc = modelPc + 12'd1;
        exec_done = 1'b0;
        for (int w = 0; w < waitCycles; w++) begin
            stepCycle();
            checkOutput("WAIT ctrl", {20'h0, obs}, {20'h0, PH_WAIT});
            run = 1'($urandom);
        end
        exec_done = 1'b1;
        run       = runAfter;
        stepCycle();
        exec_done = 1'($urandom);
        if (runAfter) begin
            checkOutput("boundary T0", {20'h0, obs}, {20'h0, PH_T0});
        end else begin
            checkOutput("boundary IDLE", {20'h0, obs}, {20'h0, PH_IDLE});
            checkOutput("IDLE d held", {24'h0, d}, {24'h0, expD});
        end
    endtask

    // Idles with run low for a few cycles, then restarts into T0
    task automatic restartFromIdle(input int idleCycles);
        run = 1'b0;
        for (int k = 0; k < idleCycles; k++) begin
            exec_done = 1'($urandom);
            stepCycle();
            checkOutput("IDLE hold", {20'h0, obs}, {20'h0, PH_IDLE});
        end
        run = 1'b1;
        stepCycle();
    endtask

    initial begin
        logic [15:0] word;
        logic [15:0] indWord;
        bit          goOn;
        checkCount = 0;
        errCount   = 0;
        modelPc    = 12'h000;
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
        rst       = 1'b0;
        run       = 1'b0;
        exec_done = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset ctrl", {20'h0, obs}, {20'h0, PH_IDLE});
        checkOutput("reset d", {24'h0, d}, 32'h0);
        checkOutput("reset i_bit", {31'h0, i_bit}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        restartFromIdle(3);

        // Directed cases from the fetch test plan
        applyStimulus(16'h2005, 16'h0000, 3, 1'b1);
        applyStimulus(16'hA010, 16'h0123, 0, 1'b1);
        applyStimulus(16'hF800, 16'h0000, 1, 1'b1);

        // Random instruction stream; operand addresses stay clear of the PC range
        for (int n = 0; n < 40; n++) begin
            word        = 16'($urandom);
            word[11:0]  = 12'h100 + 12'($urandom_range(0, 12'hEFF));
            indWord     = 16'($urandom);
            goOn        = ($urandom_range(0, 4) != 0) && (n != 39);
            applyStimulus(word, indWord, $urandom_range(0, 3), goOn);
            if (!goOn) restartFromIdle($urandom_range(1, 3));
        end

        // Reset in the middle of an indirect cycle abandons the instruction
        mem[modelPc]  = 16'hB150;
        mem[12'h150]  = 16'h0ABC;
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("pre-reset T3", {20'h0, obs}, {20'h0, PH_T3});
        checkOutput("pre-reset d", {24'h0, d}, 32'h08);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid reset ctrl", {20'h0, obs}, {20'h0, PH_IDLE});
        checkOutput("mid reset d", {24'h0, d}, 32'h0);
        checkOutput("mid reset i_bit", {31'h0, i_bit}, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        modelPc = 12'h000;
        run     = 1'b1;
        stepCycle();
        applyStimulus(16'h7123, 16'h0000, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
